// File: rtl/mem_model_pkg.sv
// Shared types and constants for the L2 backing-memory responder and its data generator.
package mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam int          LINE_W       = 512;
    localparam int          WORD_W       = 32;
    localparam int          WORDS        = 16;
    localparam logic [31:0] DEFAULT_SEED = 32'h1ACE_B00C;
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;

    // Galois LFSR, shift-right form: x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/mem_lfsr32.sv
// 32-bit Galois LFSR data-generator state; advances one step per asserted step cycle.
module mem_lfsr32
    import mem_model_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        step,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = step ? lfsr_next(state_q) : state_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/l2_backing_mem.sv
// Fixed-latency main-memory responder below the L2; reads return a predictable 512-bit line.
// Build option: define MEM_LFSR_DATA_EN for LFSR-based line data, otherwise a read-count pattern.
module l2_backing_mem
    import mem_model_pkg::*;
#(
`ifdef MEM_LFSR_DATA_EN
    parameter logic [31:0] SEED    = DEFAULT_SEED,
`endif
    parameter int unsigned LATENCY = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              read_L2_MEM,
    input  logic              write_L2_MEM,
    output logic              ready_MEM_L2,
    output logic [LINE_W-1:0] read_data_MEM_L2
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_e              state_q,  state_d;
    logic [7:0]          cnt_q,    cnt_d;
    logic                op_wr_q,  op_wr_d;
    logic                ready_q,  ready_d;
    logic [LINE_W-1:0]   data_q,   data_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [LINE_W-1:0]   gen_line;

`ifdef MEM_LFSR_DATA_EN
    logic        rd_resp;
    logic [31:0] gen_state;

    assign rd_resp = (state_q == BUSY) && (cnt_q == 8'd0) && !op_wr_q;

    mem_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .step    (rd_resp),
        .state_o (gen_state)
    );
`endif

    always_comb begin
        gen_line = '0;
        for (int k = 0; k < WORDS; k++) begin
`ifdef MEM_LFSR_DATA_EN
            gen_line[k*WORD_W +: WORD_W] = gen_state + WORD_W'(k);
`else
            gen_line[k*WORD_W +: WORD_W] = {rd_cnt_q, 8'hD0, 4'h0, 4'(k)};
`endif
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        ready_d  = 1'b0;
        data_d   = data_q;
        rd_cnt_d = rd_cnt_q;
        unique case (state_q)
            // The RESP exit edge skips sampling because L2 still holds the finished request;
            // the GAP exit edge samples again, keeping back-to-back spacing at LATENCY+2.
            IDLE, GAP: begin
                if (write_L2_MEM || read_L2_MEM) begin
                    state_d = BUSY;
                    op_wr_d = write_L2_MEM;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (!op_wr_q) begin
                        data_d   = gen_line;
                        rd_cnt_d = rd_cnt_q + 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP:    state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            op_wr_q  <= 1'b0;
            ready_q  <= 1'b0;
            data_q   <= '0;
            rd_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            ready_q  <= ready_d;
            data_q   <= data_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign ready_MEM_L2     = ready_q;
    assign read_data_MEM_L2 = data_q;

endmodule

// File: tb/tb_l2_backing_mem.sv
// Scoreboard bench: stimulus pushes expected responses, per-DUT monitors pop on each ready pulse.
module tb_l2_backing_mem;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

`ifdef MEM_LFSR_DATA_EN
    localparam logic [31:0] EXP_R1_W0  = 32'h1ACE_B00C;
    localparam logic [31:0] EXP_R1_W15 = 32'h1ACE_B01B;
    localparam logic [31:0] EXP_R2_W   = 32'h0D67_5806;
    localparam int          R2_IDX     = 0;
    localparam logic [31:0] EXP_R3_W0  = 32'h06B3_AC03;
`else
    localparam logic [31:0] EXP_R1_W0  = 32'h0000_D000;
    localparam logic [31:0] EXP_R1_W15 = 32'h0000_D00F;
    localparam logic [31:0] EXP_R2_W   = 32'h0001_D003;
    localparam int          R2_IDX     = 3;
    localparam logic [31:0] EXP_R3_W0  = 32'h0002_D000;
`endif

    logic         clk = 1'b0;
    logic         rstn;
    logic         rd_a, wr_a, rd_b, wr_b;
    logic         ready_a, ready_b;
    logic [511:0] data_a, data_b;

    always #5 clk = ~clk;

    l2_backing_mem #(.LATENCY(LAT_A)) u_dut_a (
        .clk              (clk),
        .rstn             (rstn),
        .read_L2_MEM      (rd_a),
        .write_L2_MEM     (wr_a),
        .ready_MEM_L2     (ready_a),
        .read_data_MEM_L2 (data_a)
    );

    l2_backing_mem #(.LATENCY(LAT_B)) u_dut_b (
        .clk              (clk),
        .rstn             (rstn),
        .read_L2_MEM      (rd_b),
        .write_L2_MEM     (wr_b),
        .ready_MEM_L2     (ready_b),
        .read_data_MEM_L2 (data_b)
    );

    typedef struct {
        logic [511:0] data;
        int           at;
    } exp_t;

    exp_t         q_a[$];
    exp_t         q_b[$];
    exp_t         e_a, e_b;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           n;
    logic [31:0]  lfsr_a, lfsr_b;
    logic [15:0]  cnt_a, cnt_b;
    logic [511:0] last_a;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [511:0] line_of(input logic [31:0] s, input logic [15:0] c);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) begin
`ifdef MEM_LFSR_DATA_EN
            l[k*32 +: 32] = s + 32'(k) + 32'(c & 16'h0);
`else
            l[k*32 +: 32] = {c, 8'hD0, 4'h0, 4'(k)} + (s & 32'h0);
`endif
        end
        return l;
    endfunction

    task automatic model_reset();
        lfsr_a = 32'h1ACE_B00C;
        lfsr_b = 32'h1ACE_B00C;
        cnt_a  = 16'd0;
        cnt_b  = 16'd0;
        last_a = '0;
    endtask

    task automatic expect_read_a(input int at);
        last_a = line_of(lfsr_a, cnt_a);
        q_a.push_back('{data: last_a, at: at});
        lfsr_a = lfsr_step(lfsr_a);
        cnt_a++;
    endtask

    task automatic expect_write_a(input int at);
        q_a.push_back('{data: last_a, at: at});
    endtask

    task automatic expect_read_b(input int at);
        q_b.push_back('{data: line_of(lfsr_b, cnt_b), at: at});
        lfsr_b = lfsr_step(lfsr_b);
        cnt_b++;
    endtask

    // One complete transaction on DUT A, request held until the edge after ready.
    task automatic txn_a(input logic rd, input logic wr);
        int acc;
        @(negedge clk);
        rd_a = rd;
        wr_a = wr;
        acc  = cyc + 1;
        if (wr) expect_write_a(acc + LAT_A);
        else    expect_read_a(acc + LAT_A);
        repeat (LAT_A + 2) @(negedge clk);
        rd_a = 1'b0;
        wr_a = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ready_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_ready: got pulse at edge %0d, required none", cyc);
            end else begin
                e_a = q_a.pop_front();
                check("a_data", data_a, e_a.data);
                check("a_ready_edge", 512'(cyc), 512'(e_a.at));
            end
        end
    end

    always @(negedge clk) begin
        if (ready_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_ready: got pulse at edge %0d, required none", cyc);
            end else begin
                e_b = q_b.pop_front();
                check("b_data", data_b, e_b.data);
                check("b_ready_edge", 512'(cyc), 512'(e_b.at));
            end
        end
    end

    initial begin
        rstn = 1'b0;
        rd_a = 1'b0;
        wr_a = 1'b0;
        rd_b = 1'b0;
        wr_b = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("reset_ready_a", 512'(ready_a), 512'd0);
        check("reset_data_a", data_a, '0);
        check("reset_ready_b", 512'(ready_b), 512'd0);
        check("reset_data_b", data_b, '0);

        txn_a(1'b1, 1'b0);
        check("r1_word0", 512'(data_a[31:0]), 512'(EXP_R1_W0));
        check("r1_word15", 512'(data_a[511:480]), 512'(EXP_R1_W15));

        @(negedge clk);
        txn_a(1'b1, 1'b0);
        check("r2_word", 512'(data_a[R2_IDX*32 +: 32]), 512'(EXP_R2_W));

        @(negedge clk);
        txn_a(1'b0, 1'b1);
        check("wr_data_kept", 512'(data_a[R2_IDX*32 +: 32]), 512'(EXP_R2_W));

        // Write and read together: write wins, held read follows LATENCY+2 cycles later.
        @(negedge clk);
        rd_a = 1'b1;
        wr_a = 1'b1;
        n    = cyc + 1;
        expect_write_a(n + LAT_A);
        expect_read_a(n + 2 * LAT_A + 2);
        repeat (LAT_A + 2) @(negedge clk);
        wr_a = 1'b0;
        repeat (LAT_A + 2) @(negedge clk);
        rd_a = 1'b0;
        check("b2b_word0", 512'(data_a[31:0]), 512'(EXP_R3_W0));

        // Reset while BUSY drops the transaction without a pulse.
        @(negedge clk);
        rd_a = 1'b1;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midrst_ready", 512'(ready_a), 512'd0);
        check("midrst_data", data_a, '0);
        rd_a = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;

        @(negedge clk);
        txn_a(1'b1, 1'b0);
        check("post_rst_word0", 512'(data_a[31:0]), 512'(EXP_R1_W0));

        // LATENCY=1 with the read held across GAP: exactly two pulses.
        @(negedge clk);
        rd_b = 1'b1;
        n    = cyc + 1;
        expect_read_b(n + LAT_B);
        expect_read_b(n + 2 * LAT_B + 2);
        repeat (5) @(negedge clk);
        rd_b = 1'b0;
        repeat (6) @(negedge clk);

        check("a_pending", 512'(q_a.size()), 512'd0);
        check("b_pending", 512'(q_b.size()), 512'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
